// File: rtl/pattern_loader.sv
// -----------------------------------------------------------------------------
// pattern_loader
//
// Streams one frame of BUF_SIZE pattern bytes from a valid/ready source into
// the pattern buffer's serial port, MSB first. While shifting, it captures the
// buffer's previous contents from sout and returns them as readback bytes.
//
// Ports:
//   clk, rst_n          system clock (posedge), asynchronous active-low reset
//   start               one-cycle pulse, begins a frame when idle
//   busy                high from the cycle after an accepted start until done
//   wr_data/valid/ready pattern byte stream into the loader
//   rd_data/rd_valid    readback byte stream (old buffer contents), no backpressure
//   done                one-cycle pulse at frame end
//   sclk/ssel/sin       serial clock, select and data to the pattern buffer
//   sout                serial data from the pattern buffer
// -----------------------------------------------------------------------------
module pattern_loader #(
  parameter int BUF_WIDTH   = 8,
  parameter int BUF_SIZE    = 32,
  parameter int HALF_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  input  logic [BUF_WIDTH-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [BUF_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 sclk,
  output logic                 ssel,
  output logic                 sin,
  input  logic                 sout
);

  localparam int BIT_W = (BUF_WIDTH > 1) ? $clog2(BUF_WIDTH) : 1;
  localparam int CNT_W = $clog2(BUF_SIZE + 1);
  localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BUF_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUF_SIZE - 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 wr_ready_q, wr_ready_d;
  logic                 hold_full_q, hold_full_d;
  logic [BUF_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;    // bytes accepted this frame
  logic [CNT_W-1:0]     sent_cnt_q, sent_cnt_d;  // bytes fully shifted out
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [HP_W-1:0]      hp_cnt_q, hp_cnt_d;
  logic [BUF_WIDTH-1:0] shift_q, shift_d;
  logic [BUF_WIDTH-1:0] rd_shift_q, rd_shift_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [BUF_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 done_q, done_d;
  logic                 sclk_q, sclk_d;
  logic                 ssel_q, ssel_d;
  logic                 sin_q, sin_d;
  logic                 load_s;
  logic                 accept_s;

  assign accept_s = wr_valid && wr_ready_q;

  // Next-state logic: frame sequencing, bit timing, holding register and readback.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    acc_cnt_d   = acc_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    hp_cnt_d    = hp_cnt_q;
    shift_d     = shift_q;
    rd_shift_d  = rd_shift_q;
    rd_pend_d   = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    sclk_d      = sclk_q;
    ssel_d      = ssel_q;
    sin_d       = sin_q;
    load_s      = 1'b0;

    // A completed readback byte is presented one cycle after its 8th sample.
    if (rd_pend_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_shift_q;
    end else begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          busy_d      = 1'b1;
          acc_cnt_d   = '0;
          sent_cnt_d  = '0;
          hold_full_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // Underrun stall: sclk stays low and ssel keeps its value until a byte arrives.
        if (hold_full_q) begin
          load_s = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SHIFT: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d = '0;
          if (!sclk_q) begin
            // Rising sclk: the buffer still presents the pre-shift bit on sout.
            sclk_d     = 1'b1;
            rd_shift_d = {rd_shift_q[BUF_WIDTH-2:0], sout};
            rd_pend_d  = (bit_cnt_q == BIT_LAST);
          end else if (bit_cnt_q != BIT_LAST) begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = {shift_q[BUF_WIDTH-2:0], 1'b0};
            sin_d     = shift_q[BUF_WIDTH-2];
          end else begin
            sclk_d     = 1'b0;
            sent_cnt_d = sent_cnt_q + CNT_W'(1);
            if (sent_cnt_q == CNT_LAST) begin
              state_d = S_END;
              ssel_d  = 1'b0;
              sin_d   = 1'b0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (hold_full_q) begin
              // Next byte already waiting: continue without a gap.
              load_s = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Load and accept are exclusive: load needs a full holding register, accept an empty one.
    if (load_s) begin
      state_d     = S_SHIFT;
      shift_d     = hold_data_q;
      sin_d       = hold_data_q[BUF_WIDTH-1];
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
      hp_cnt_d    = '0;
      sclk_d      = 1'b0;
      ssel_d      = 1'b1;
    end else if (accept_s) begin
      hold_full_d = 1'b1;
      hold_data_d = wr_data;
      acc_cnt_d   = acc_cnt_q + CNT_W'(1);
    end else begin
      hold_full_d = hold_full_q;
    end

    wr_ready_d = busy_d && !hold_full_d && (acc_cnt_d < CNT_FULL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      acc_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      hp_cnt_q    <= '0;
      shift_q     <= '0;
      rd_shift_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ssel_q      <= 1'b0;
      sin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      acc_cnt_q   <= acc_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hp_cnt_q    <= hp_cnt_d;
      shift_q     <= shift_d;
      rd_shift_q  <= rd_shift_d;
      rd_pend_q   <= rd_pend_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      sclk_q      <= sclk_d;
      ssel_q      <= ssel_d;
      sin_q       <= sin_d;
    end
  end

  assign busy     = busy_q;
  assign wr_ready = wr_ready_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign ssel     = ssel_q;
  assign sin      = sin_q;

endmodule

// File: tb/tb_pattern_loader.sv
// -----------------------------------------------------------------------------
// tb_pattern_loader
//
// Two loaders (HALF_PERIOD=2 and HALF_PERIOD=1), each attached to a behavioural
// 256-bit pattern buffer. Frames are described in a table and driven with
// $urandom data and valid gaps; the expected buffer image and readback bytes
// come from the stream-order rule (stream byte i -> entry BUF_SIZE-1-i).
// -----------------------------------------------------------------------------
module tb_pattern_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v, busy_v, wr_valid_v, wr_ready_v, rd_valid_v, done_v;
  logic [1:0] sclk_v, ssel_v, sin_v, sout_v;
  logic [7:0] wr_data_v [2];
  logic [7:0] rd_data_v [2];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pattern_loader #(.BUF_WIDTH(8), .BUF_SIZE(32), .HALF_PERIOD(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]),
    .wr_data(wr_data_v[0]), .wr_valid(wr_valid_v[0]), .wr_ready(wr_ready_v[0]),
    .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .done(done_v[0]),
    .sclk(sclk_v[0]), .ssel(ssel_v[0]), .sin(sin_v[0]), .sout(sout_v[0])
  );

  pattern_loader #(.BUF_WIDTH(8), .BUF_SIZE(32), .HALF_PERIOD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]),
    .wr_data(wr_data_v[1]), .wr_valid(wr_valid_v[1]), .wr_ready(wr_ready_v[1]),
    .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .done(done_v[1]),
    .sclk(sclk_v[1]), .ssel(ssel_v[1]), .sin(sin_v[1]), .sout(sout_v[1])
  );

  // Pattern buffer model: entry e = bits[8e+7:8e]; shifts in at entry 0 LSB,
  // sout is the MSB of the last entry.
  logic [255:0] buf_bits [2] = '{ {8{32'h5A3C_96E1}}, {8{32'h0F1E_2D3C}} };
  int           rise_cnt [2] = '{0, 0};

  for (genvar g = 0; g < 2; g++) begin : g_buf
    assign sout_v[g] = buf_bits[g][255];
    always @(posedge sclk_v[g]) begin
      rise_cnt[g] <= rise_cnt[g] + 1;
      if (ssel_v[g]) buf_bits[g] <= {buf_bits[g][254:0], sin_v[g]};
    end
  end

  typedef struct {
    int         inst;
    bit         rnd;
    logic [7:0] xorv;
    int         stall_after;
    int         stall_len;
    bit         rand_valid;
    bit         extra_start;
    int         abort_bits;
    int         exp_cycles;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int           k;
    logic [7:0]   data [32];
    logic [7:0]   rd_q [$];
    logic [255:0] old_bits;
    int           idx, cyc, ssel_cyc, done_cnt, rise0, stall_cnt;
    bit           stall_bad, got_done, post_bad;
    k = v.inst;
    for (int i = 0; i < 32; i++) data[i] = v.rnd ? 8'($urandom) : (8'(i) ^ v.xorv);
    old_bits  = buf_bits[k];
    rise0     = rise_cnt[k];
    idx       = 0; cyc = 0; ssel_cyc = 0; done_cnt = 0; stall_cnt = 0;
    stall_bad = 1'b0; got_done = 1'b0; post_bad = 1'b0;

    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
    check("busy_after_start", busy_v[k], 1);
    check("ready_after_start", wr_ready_v[k], 1);

    while (!got_done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (rd_valid_v[k]) rd_q.push_back(rd_data_v[k]);
      if (ssel_v[k]) ssel_cyc++;
      if (done_v[k]) begin
        got_done = 1'b1;
        done_cnt++;
        check("busy_low_at_done", busy_v[k], 0);
      end
      if (v.abort_bits > 0 && (rise_cnt[k] - rise0) >= v.abort_bits) begin
        // Asynchronous reset between clock edges, mid-frame.
        #2 rst_n = 1'b0;
        #1 check("abort_outputs_low", {sclk_v[k], ssel_v[k], busy_v[k]}, 0);
        wr_valid_v[k] = 1'b0;
        start_v[k]    = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start_v[k] = v.extra_start && (cyc == 200 || got_done);
      if (idx == v.stall_after + 1 && stall_cnt < v.stall_len) begin
        wr_valid_v[k] = 1'b0;
        stall_cnt++;
        if (stall_cnt > v.stall_len - 40 && (sclk_v[k] !== 1'b0 || ssel_v[k] !== 1'b1))
          stall_bad = 1'b1;
      end else begin
        wr_valid_v[k] = (idx < 32) && (!v.rand_valid || $urandom_range(0, 3) != 0);
        wr_data_v[k]  = data[(idx < 32) ? idx : 31];
        if (wr_valid_v[k] && wr_ready_v[k]) idx++;
      end
    end
    wr_valid_v[k] = 1'b0;

    if (!got_done) begin
      n_vec++; n_fail++;
      $display("FAIL frame_timeout: inst %0d no done after %0d cycles, expected done", k, cyc);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      start_v[k] = 1'b0;
      return;
    end

    // After done: no restart from a start in the done cycle, no extra pulses.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_v[k] = 1'b0;
      if (busy_v[k] || done_v[k] || rd_valid_v[k]) post_bad = 1'b1;
    end

    check("quiet_after_done", post_bad, 0);
    check("done_pulses", done_cnt, 1);
    check("sclk_rises", rise_cnt[k] - rise0, 256);
    check("rd_count", rd_q.size(), 32);
    for (int i = 0; i < 32 && i < rd_q.size(); i++)
      check($sformatf("rd_byte%0d", i), rd_q[i], old_bits[8*(31-i) +: 8]);
    for (int i = 0; i < 32; i++)
      check($sformatf("entry%0d", 31 - i), buf_bits[k][8*(31-i) +: 8], data[i]);
    if (v.exp_cycles > 0) check("frame_cycles", ssel_cyc, v.exp_cycles);
    if (v.stall_len > 0) check("underrun_stall_hold", stall_bad, 0);
  endtask

  initial begin
    int  r0;
    bit  bad;
    rst_n        = 1'b0;
    start_v      = 2'b00;
    wr_valid_v   = 2'b00;
    wr_data_v[0] = 8'h00;
    wr_data_v[1] = 8'h00;

    //        inst rnd xorv   stall_after len rand_v xstart abort exp_cyc
    vt[0] = '{0,   0,  8'h00, 0,          0,  0,     0,     0,    1024};
    vt[1] = '{0,   0,  8'hA5, 0,          0,  0,     0,     0,    1024};
    vt[2] = '{0,   1,  8'h00, 5,          120, 0,    0,     0,    -1};
    vt[3] = '{0,   1,  8'h00, 0,          0,  1,     0,     0,    -1};
    vt[4] = '{0,   1,  8'h00, 0,          0,  0,     0,     100,  -1};
    vt[5] = '{0,   1,  8'h00, 0,          0,  0,     0,     0,    1024};
    vt[6] = '{1,   0,  8'h3C, 0,          0,  0,     1,     0,    512};
    vt[7] = '{1,   1,  8'h00, 3,          80, 1,     0,     0,    -1};

    // Reset state of both instances, checked between clock edges.
    #12;
    for (int k = 0; k < 2; k++)
      check($sformatf("reset_outputs%0d", k),
            {sclk_v[k], ssel_v[k], sin_v[k], busy_v[k], wr_ready_v[k],
             rd_valid_v[k], done_v[k], rd_data_v[k]}, 0);

    // Idle after reset release: no activity without start.
    @(negedge clk);
    rst_n = 1'b1;
    r0    = rise_cnt[0];
    bad   = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (wr_ready_v[0] || sclk_v[0] || busy_v[0]) bad = 1'b1;
    end
    check("idle_no_activity", bad, 0);
    check("idle_no_sclk_edges", rise_cnt[0] - r0, 0);

    for (int i = 0; i < 8; i++) run_frame(vt[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
# pattern_loader

Serial loader for the pattern buffer. Takes 32 pattern bytes from a system-side valid/ready stream and shifts them into the buffer's serial port (sclk/ssel/sin). At the same time it captures the buffer's previous contents from sout and returns them as a readback byte stream. It sits between the host/register interface and the pattern buffer, and is the only driver of the buffer's serial pins.

## Interface
- BUF_WIDTH, 8, bits per pattern byte
- BUF_SIZE, 32, bytes per frame (frame = BUF_WIDTH*BUF_SIZE bits)
- HALF_PERIOD, 2, clk cycles per sclk half-period (>=1)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a frame when idle
- busy  output  1  high from the cycle after an accepted start until done
- wr_data  input  BUF_WIDTH  next pattern byte
- wr_valid  input  1  wr_data valid
- wr_ready  output  1  loader accepts wr_data this cycle
- rd_data  output  BUF_WIDTH  readback byte (old buffer contents)
- rd_valid  output  1  one-cycle pulse, rd_data valid; no backpressure
- done  output  1  one-cycle pulse at frame end
- sclk  output  1  serial clock to pattern buffer
- ssel  output  1  serial select to pattern buffer
- sin  output  1  serial data to pattern buffer
- sout  input  1  serial data from pattern buffer (old MSB of last byte)

## Operation
- The buffer shifts on every sclk rising edge while ssel=1. The first bit shifted in ends up at the MSB of the last buffer entry.
- Bytes are therefore sent in stream order, MSB first. Stream byte i lands in buffer entry BUF_SIZE-1-i.
- States:
  - IDLE: start=1 -> FETCH. start while busy is ignored.
  - FETCH: waits for the holding register to fill, then loads the shift register -> SHIFT.
  - SHIFT: sends 8 bits. After the 8th bit: -> FETCH if fewer than BUF_SIZE bytes are sent, otherwise -> END.
  - END: pulses done, clears busy -> IDLE.
- Holding register: one byte deep.
  - wr_ready=1 when busy, the holding register is empty, and fewer than BUF_SIZE bytes have been accepted.
  - A byte is accepted on wr_valid&&wr_ready.
  - wr_ready=0 in IDLE and once BUF_SIZE bytes have been accepted.
- Underrun: if the holding register is empty when a byte is needed, the loader stalls in FETCH with sclk=0 and ssel held. No sclk edges occur, so the buffer state is preserved. Shifting resumes when a byte arrives.
- Readback:
  - sout is sampled at the same clk edge that raises sclk, i.e. the pre-shift value.
  - Samples are assembled MSB first.
  - After each 8th sample, rd_data is presented with rd_valid=1 for one cycle.
  - Readback byte i equals the old buffer entry BUF_SIZE-1-i.
- Counters: a bit counter of 3 bits and a byte counter of ceil(log2(BUF_SIZE+1)) bits, plus a half-period counter. The byte counter never wraps; it resets at start.
- Reset (at any time, including mid-frame):
  - sclk=0, ssel=0, sin=0, busy=0, wr_ready=0, rd_valid=0, done=0, rd_data=0.
  - The state machine returns to IDLE and the holding register is emptied.
  - A partially shifted buffer is left as-is; software reloads it.

## Timing
- start accepted at clk edge T0 -> busy=1 and wr_ready=1 from T0+1.
- Each bit takes 2*HALF_PERIOD clk cycles: a low phase (sclk=0) followed by a high phase (sclk=1).
- sin changes only at the start of a low phase and is stable for the whole low and high phase of its bit.
- ssel rises together with the first low phase and falls at the end of the last high phase. ssel never changes while sclk=1.
- With no stalls, a frame lasts BUF_SIZE*BUF_WIDTH*2*HALF_PERIOD clk cycles from the first low phase: 1024 cycles at the defaults.
- The holding register lets the next byte be accepted during the current byte, so a continuously valid stream causes no gaps.
- rd_valid is asserted one clk cycle after the edge that samples the 8th bit of a byte.
- done=1 and busy=0 are asserted at the edge where sclk falls after the last bit. The final rd_valid is asserted at or before that edge.
- A start issued in the done cycle is ignored. A start issued the cycle after is accepted.

## Test plan
- Reset: with rst_n=0, all outputs are 0. Release reset with no start for 100 cycles -> no sclk edges, wr_ready=0.
- Load: start, then stream 0x00..0x1F with wr_valid held high. A behavioural buffer model must hold entry[31-i]=i. Exactly 256 sclk rising edges, 1024 cycles, done pulses once.
- Readback: a second frame streams 0xA5^i. rd_data sequence must be 0x00..0x1F, 32 rd_valid pulses, and the model must end with entry[31-i]=0xA5^i.
- Underrun: drop wr_valid after byte 5 for 40 cycles -> sclk stays 0 with no edges, ssel stays 1. The final buffer contents must be correct.
- Reset mid-frame: assert rst_n=0 after 100 bits, with reset asserted asynchronously between clk edges -> sclk, ssel and busy go 0 immediately. A subsequent full frame loads correctly.
- Parameters: HALF_PERIOD=1, and start pulsed again while busy -> 512-cycle frame, the extra start is ignored, exactly one done pulse.
